// File: rtl/fifo_pkg.sv
// Shared definitions for the circular FIFO.
// Contents:
//   clog2    - ceiling log2, used for the occupancy and pointer widths
//   ALL_ZERO - wide zero constant, sliced to word/pointer width for clearing
package fifo_pkg;

    localparam logic [255:0] ALL_ZERO = '0;

    // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_circ_if.sv
// Handshake/status bundle between a producer/consumer and fifo_circ.
// Signals:
//   in, push, pop                         - driven by the user (master)
//   out, valid, full, empty, almost_full,
//   almost_empty, count, overflow,
//   underflow, debug_queue                - driven by the FIFO (slave)
interface fifo_circ_if #(
    parameter int N = 4,
    parameter int M = 2
);
    localparam int CW = fifo_pkg::clog2(N + 1);

    logic [M-1:0]   in;
    logic           push;
    logic           pop;
    logic [M-1:0]   out;
    logic           valid;
    logic           full;
    logic           empty;
    logic           almost_full;
    logic           almost_empty;
    logic [CW-1:0]  count;
    logic           overflow;
    logic           underflow;
    logic [M*N-1:0] debug_queue;

    modport master (
        output in, push, pop,
        input  out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, debug_queue
    );

    modport slave (
        input  in, push, pop,
        output out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, debug_queue
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping slot pointer 0..N-1 for the circular FIFO.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, clears ptr to 0
//   inc   - advance the pointer by one slot
//   ptr   - current slot index
// The wrap is an explicit compare against N-1 so any depth works.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [clog2(N)-1:0]   ptr
);
    localparam int PW = clog2(N);

    logic [PW-1:0] ptr_r;

    // Pointer register: clear, advance with wrap, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= ALL_ZERO[PW-1:0];
        end else if (inc) begin
            ptr_r <= (ptr_r == PW'(N - 1)) ? ALL_ZERO[PW-1:0] : ptr_r + PW'(1'b1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fifo_circ.sv
// Circular-buffer FIFO of N words of M bits.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous active-high reset, priority over push/pop
//   bus   - fifo_circ_if slave: in/push/pop requests; registered out/valid,
//           overflow/underflow pulses, count, flags and raw storage view
// Flags are decoded from the registered count, so no input reaches an
// output combinationally.
module fifo_circ
    import fifo_pkg::*;
#(
    parameter int N      = 4,
    parameter int M      = 2,
    parameter int AF_LVL = N - 1,
    parameter int AE_LVL = 1
) (
    input  logic      clk,
    input  logic      reset,
    fifo_circ_if.slave bus
);
    localparam int CW = clog2(N + 1);
    localparam int PW = clog2(N);

    logic [M-1:0]   mem_r [N];
    logic [M-1:0]   out_r;
    logic           valid_r;
    logic           overflow_r;
    logic           underflow_r;
    logic [CW-1:0]  count_r;
    logic [PW-1:0]  wr_ptr_s;
    logic [PW-1:0]  rd_ptr_s;
    logic           full_s;
    logic           empty_s;
    logic           push_ok_s;
    logic           pop_ok_s;
    logic [M*N-1:0] debug_s;

    // A push into a full queue is still accepted when a pop frees the head
    // in the same cycle; a pop from an empty queue never falls through.
    assign pop_ok_s  = bus.pop & ~empty_s;
    assign push_ok_s = bus.push & (~full_s | pop_ok_s);

    fifo_ptr #(.N(N)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_ok_s),
        .ptr   (wr_ptr_s)
    );

    fifo_ptr #(.N(N)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_ok_s),
        .ptr   (rd_ptr_s)
    );

    // Storage: clear on reset, write the accepted word at the write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= ALL_ZERO[M-1:0];
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_s] <= bus.in;
        end else begin
            mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
        end
    end

    // Read data, event pulses and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r       <= ALL_ZERO[M-1:0];
            valid_r     <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            count_r     <= ALL_ZERO[CW-1:0];
        end else begin
            if (pop_ok_s) begin
                out_r <= mem_r[rd_ptr_s];
            end else begin
                out_r <= out_r;
            end
            valid_r     <= pop_ok_s;
            overflow_r  <= bus.push & ~push_ok_s;
            underflow_r <= bus.pop & ~pop_ok_s;
            count_r     <= count_r + {{(CW-1){1'b0}}, push_ok_s}
                                   - {{(CW-1){1'b0}}, pop_ok_s};
        end
    end

    // Raw storage view, slot i at bits [M*i +: M].
    always_comb begin
        debug_s = '0;
        for (int i = 0; i < N; i++) begin
            debug_s[M*i +: M] = mem_r[i];
        end
    end

    assign full_s  = (count_r == CW'(N));
    assign empty_s = (count_r == ALL_ZERO[CW-1:0]);

    assign bus.out          = out_r;
    assign bus.valid        = valid_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
    assign bus.count        = count_r;
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = (count_r >= CW'(AF_LVL));
    assign bus.almost_empty = (count_r <= CW'(AE_LVL));
    assign bus.debug_queue  = debug_s;

endmodule

// File: tb/tb_fifo_circ.sv
// Self-checking bench for fifo_circ: DUT A (N=4, M=2) and DUT B (N=5, M=3).
// A queue-level model predicts every output each cycle; directed sequences
// add hand-computed literal expectations.
module tb_fifo_circ;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_circ_if #(.N(4), .M(2)) bus_a ();
    fifo_circ_if #(.N(5), .M(3)) bus_b ();

    fifo_circ #(.N(4), .M(2)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a.slave));
    fifo_circ #(.N(5), .M(3)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b.slave));

    // ---------------- behavioural model (index 0 = A, 1 = B) ----------------
    int cap [2] = '{4, 5};
    int mw  [2] = '{2, 3};
    int items [2][8];   // queue contents, items[d][0] is the oldest word
    int slot  [2][8];   // raw storage image
    int cnt   [2];
    int wpos  [2];      // accepted pushes modulo depth
    int e_out [2];
    int e_val [2];
    int e_ovf [2];
    int e_unf [2];
    bit mdl_ok = 1'b0;

    task automatic model_step(input int d, input bit r, input bit p, input bit o, input int x);
        bit pop_acc;
        bit push_acc;
        if (r) begin
            cnt[d] = 0; wpos[d] = 0; e_out[d] = 0; e_val[d] = 0; e_ovf[d] = 0; e_unf[d] = 0;
            for (int i = 0; i < 8; i++) begin
                slot[d][i] = 0;
                items[d][i] = 0;
            end
        end else begin
            pop_acc  = o && (cnt[d] > 0);
            push_acc = p && ((cnt[d] < cap[d]) || pop_acc);
            e_val[d] = pop_acc ? 1 : 0;
            e_unf[d] = (o && !pop_acc) ? 1 : 0;
            e_ovf[d] = (p && !push_acc) ? 1 : 0;
            if (pop_acc) begin
                e_out[d] = items[d][0];
                for (int i = 0; i < 7; i++) items[d][i] = items[d][i+1];
                cnt[d] = cnt[d] - 1;
            end
            if (push_acc) begin
                items[d][cnt[d]] = x;
                cnt[d] = cnt[d] + 1;
                slot[d][wpos[d]] = x;
                wpos[d] = (wpos[d] + 1) % cap[d];
            end
        end
    endtask

    // Model advances on the same edge as the DUTs, from the pre-edge inputs.
    always @(posedge clk) begin
        model_step(0, rst_a, bus_a.push, bus_a.pop, int'(bus_a.in));
        model_step(1, rst_b, bus_b.push, bus_b.pop, int'(bus_b.in));
        if (rst_a && rst_b) mdl_ok = 1'b1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_dbg(input int d);
        int e;
        e = 0;
        for (int i = 0; i < cap[d]; i++) e = e | (slot[d][i] << (mw[d] * i));
        return e;
    endfunction

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("a_count", int'(bus_a.count), cnt[0]);
            chk("a_full",  int'(bus_a.full),  (cnt[0] == cap[0]) ? 1 : 0);
            chk("a_empty", int'(bus_a.empty), (cnt[0] == 0) ? 1 : 0);
            chk("a_afull", int'(bus_a.almost_full),  (cnt[0] >= cap[0] - 1) ? 1 : 0);
            chk("a_aempty",int'(bus_a.almost_empty), (cnt[0] <= 1) ? 1 : 0);
            chk("a_out",   int'(bus_a.out),   e_out[0]);
            chk("a_valid", int'(bus_a.valid), e_val[0]);
            chk("a_ovf",   int'(bus_a.overflow),  e_ovf[0]);
            chk("a_unf",   int'(bus_a.underflow), e_unf[0]);
            chk("a_dbg",   int'(bus_a.debug_queue), exp_dbg(0));
            chk("b_count", int'(bus_b.count), cnt[1]);
            chk("b_full",  int'(bus_b.full),  (cnt[1] == cap[1]) ? 1 : 0);
            chk("b_empty", int'(bus_b.empty), (cnt[1] == 0) ? 1 : 0);
            chk("b_afull", int'(bus_b.almost_full),  (cnt[1] >= cap[1] - 1) ? 1 : 0);
            chk("b_aempty",int'(bus_b.almost_empty), (cnt[1] <= 1) ? 1 : 0);
            chk("b_out",   int'(bus_b.out),   e_out[1]);
            chk("b_valid", int'(bus_b.valid), e_val[1]);
            chk("b_ovf",   int'(bus_b.overflow),  e_ovf[1]);
            chk("b_unf",   int'(bus_b.underflow), e_unf[1]);
            chk("b_dbg",   int'(bus_b.debug_queue), exp_dbg(1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_op(input bit p, input bit o, input int x);
        bus_a.push = p; bus_a.pop = o; bus_a.in = x[1:0];
        tick();
        bus_a.push = 1'b0; bus_a.pop = 1'b0;
    endtask

    task automatic b_op(input bit p, input bit o, input int x);
        bus_b.push = p; bus_b.pop = o; bus_b.in = x[2:0];
        tick();
        bus_b.push = 1'b0; bus_b.pop = 1'b0;
    endtask

    int seq_a [4];
    int v;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.push = 1'b0; bus_a.pop = 1'b0; bus_a.in = 2'd0;
        bus_b.push = 1'b0; bus_b.pop = 1'b0; bus_b.in = 3'd0;
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset state.
        chk("lit_rst_count", int'(bus_a.count), 0);
        chk("lit_rst_empty", int'(bus_a.empty), 1);
        chk("lit_rst_aempty", int'(bus_a.almost_empty), 1);
        chk("lit_rst_full", int'(bus_a.full), 0);
        chk("lit_rst_out", int'(bus_a.out), 0);
        chk("lit_rst_valid", int'(bus_a.valid), 0);
        chk("lit_rst_dbg", int'(bus_a.debug_queue), 0);

        // Fill 1,2,3,0 then overflow.
        a_op(1, 0, 1); chk("lit_fill_c1", int'(bus_a.count), 1);
        a_op(1, 0, 2); chk("lit_fill_c2", int'(bus_a.count), 2);
        a_op(1, 0, 3); chk("lit_fill_af", int'(bus_a.almost_full), 1);
        chk("lit_fill_nfull", int'(bus_a.full), 0);
        a_op(1, 0, 0); chk("lit_fill_full", int'(bus_a.full), 1);
        a_op(1, 0, 3); chk("lit_ovf", int'(bus_a.overflow), 1);
        chk("lit_ovf_count", int'(bus_a.count), 4);
        chk("lit_ovf_dbg", int'(bus_a.debug_queue), 8'b00_11_10_01);

        // Drain, then underflow.
        seq_a = '{1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            a_op(0, 1, 0);
            chk("lit_drain_out", int'(bus_a.out), seq_a[i]);
            chk("lit_drain_valid", int'(bus_a.valid), 1);
        end
        chk("lit_drain_empty", int'(bus_a.empty), 1);
        a_op(0, 1, 0);
        chk("lit_unf", int'(bus_a.underflow), 1);
        chk("lit_unf_out", int'(bus_a.out), 0);
        chk("lit_unf_valid", int'(bus_a.valid), 0);

        // Wrap-around.
        a_op(1, 0, 1); a_op(1, 0, 2); a_op(1, 0, 3);
        a_op(0, 1, 0); a_op(0, 1, 0);
        a_op(1, 0, 2); a_op(1, 0, 3); a_op(1, 0, 1);
        seq_a = '{3, 2, 3, 1};
        for (int i = 0; i < 4; i++) begin
            a_op(0, 1, 0);
            chk("lit_wrap_out", int'(bus_a.out), seq_a[i]);
        end
        chk("lit_wrap_count", int'(bus_a.count), 0);

        // Full queue with simultaneous push and pop.
        a_op(1, 0, 0); a_op(1, 0, 1); a_op(1, 0, 2); a_op(1, 0, 3);
        a_op(1, 1, 2);
        chk("lit_sim_count", int'(bus_a.count), 4);
        chk("lit_sim_out", int'(bus_a.out), 0);
        chk("lit_sim_ovf", int'(bus_a.overflow), 0);
        seq_a = '{1, 2, 3, 2};
        for (int i = 0; i < 4; i++) begin
            a_op(0, 1, 0);
            chk("lit_sim_drain", int'(bus_a.out), seq_a[i]);
        end

        // Empty queue with simultaneous push and pop.
        a_op(1, 1, 1);
        chk("lit_emp_count", int'(bus_a.count), 1);
        chk("lit_emp_unf", int'(bus_a.underflow), 1);
        chk("lit_emp_valid", int'(bus_a.valid), 0);
        a_op(0, 1, 0);
        chk("lit_emp_out", int'(bus_a.out), 1);

        // Non-power-of-two depth: three rounds of five pushes and pops.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) b_op(1, 0, (r * 5 + k + 1) % 8);
            chk("lit_b_full", int'(bus_b.full), 1);
            for (int k = 0; k < 5; k++) begin
                b_op(0, 1, 0);
                v = (r * 5 + k + 1) % 8;
                chk("lit_b_out", int'(bus_b.out), v);
            end
        end

        // Reset mid-stream, with a push in the same cycle.
        b_op(1, 0, 6); b_op(1, 0, 7);
        chk("lit_b_pre_rst", int'(bus_b.count), 2);
        rst_b = 1'b1;
        b_op(1, 0, 5);
        rst_b = 1'b0;
        chk("lit_b_rst_count", int'(bus_b.count), 0);
        chk("lit_b_rst_dbg", int'(bus_b.debug_queue), 0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_circ.md
Name: fifo_circ

Overview:
- Parametrised successor to the team's shift-register queue.
- Circular-buffer FIFO with read/write pointers, any depth N ≥ 2 (not limited to powers of two), and arbitrary word width M.
- Adds empty, almost-full and almost-empty flags, an occupancy count, registered read data with a valid strobe, and overflow/underflow error pulses.
- Sits between lab producer/consumer blocks as the standard buffering element.

Parameters:
- N, 4, maximum number of words stored (N ≥ 2).
- M, 2, bit-width of each word (M ≥ 1).
- AF_LVL, N-1, almost_full asserts when count ≥ AF_LVL (1..N).
- AE_LVL, 1, almost_empty asserts when count ≤ AE_LVL (0..N-1).

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high reset.
- in, in, M, write data, sampled when a push is accepted.
- push, in, 1, write request.
- pop, in, 1, read request.
- out, out, M, registered read data; holds last popped word.
- valid, out, 1, one-cycle pulse: out updated by the previous cycle's accepted pop.
- full, out, 1, count == N.
- empty, out, 1, count == 0.
- almost_full, out, 1, count ≥ AF_LVL.
- almost_empty, out, 1, count ≤ AE_LVL.
- count, out, CW, occupancy 0..N, where CW = clog2(N+1).
- overflow, out, 1, one-cycle pulse: push rejected.
- underflow, out, 1, one-cycle pulse: pop rejected.
- debug_queue, out, M*N, raw storage; slot i at bits [M*i +: M], not reordered.

Behaviour:
- Reset: synchronous, active-high, sampled on the clk rising edge.
  - wr_ptr, rd_ptr, count, out, valid, overflow, underflow and all storage slots clear to 0.
  - Resulting outputs: empty=1, full=0, almost_empty=1 (since AE_LVL ≥ 0), almost_full=0.
  - Reset has priority over push/pop in the same cycle; reset mid-stream discards all contents.
- Accept rules, evaluated on registered state at the edge:
  - push_ok = push & (!full | pop_ok).
  - pop_ok = pop & !empty.
- Push when full together with pop: both accepted. The pop frees the head slot and the pushed word enters at wr_ptr; count is unchanged.
- Push when empty together with pop: push accepted, pop rejected (no fall-through). underflow pulses and count becomes 1.
- Push while full without pop: word dropped, storage untouched, overflow=1 for one cycle.
- Pop while empty: underflow=1 for one cycle; out holds its value, valid=0.
- On push_ok: mem[wr_ptr] <= in; wr_ptr <= (wr_ptr == N-1) ? 0 : wr_ptr+1.
- On pop_ok:
  - out <= mem[rd_ptr]; valid <= 1 next cycle.
  - rd_ptr advances with the same wrap rule.
  - Read latency is one cycle from pop to out/valid.
- count update: count <= count + push_ok - pop_ok, evaluated at width CW; never exceeds N and never goes below 0.
- Flags (full, empty, almost_full, almost_empty) are combinational from registered count, so they reflect the state after the last edge.
- Pointers are log2ceil(N) bits wide. Wrap is explicit compare-to-N-1, not natural overflow, so non-power-of-two N works.
- valid, overflow and underflow are registered single-cycle pulses and return to 0 when no event occurs.
- No combinational path from in/push/pop to any output.

Decomposition:
- Shared package fifo_pkg:
  - clog2 width function, used for CW and pointer width.
  - Constant zero for word/pointer clearing.
- One sub-module, fifo_ptr: parameter N, inputs clk/reset/inc, output ptr, wraps at N-1. Instantiated twice, for wr_ptr and rd_ptr.
- Storage, count and flag logic stay in fifo_circ.

Test Plan (N=4, M=2, AF_LVL=3, AE_LVL=1 unless noted):
- Reset then idle: after reset cycle, count=0, empty=1, almost_empty=1, full=0, out=0, valid=0, debug_queue=0.
- Push 1,2,3,0 on consecutive cycles:
  - count steps 1,2,3,4; almost_full=1 at count 3; full=1 at 4.
  - A 5th push of 3 gives overflow pulse, count stays 4, debug_queue=8'b00_11_10_01.
- Pop four times from full queue:
  - out=1,2,3,0 each one cycle after its pop, with valid=1 each cycle.
  - empty=1 after the last; a 5th pop gives underflow pulse, out stays 0.
- Wrap-around: push 1,2,3; pop 2×; push 2,3,1; pop 4× → out sequence 3,2,3,1, proving rd/wr pointer wrap; count returns to 0.
- Simultaneous ops:
  - Full queue with push=1, pop=1, in=2: count stays 4, head popped, 2 stored, no overflow.
  - Empty queue with push=1, pop=1: count=1, underflow pulse, valid=0.
- Non-power-of-two (N=5, M=3): push 5, pop 5, repeated 3 times → data order preserved across wrap at slot 4; reset asserted mid-stream clears count to 0 on the next edge.
